// File: rtl/pix_goe_counter.sv
// pix_goe_counter: pipelined masked pixel-multiplicity counter with two stretched ">= threshold" triggers.
// Build option: define PIX_GOE_PEAK_CAPTURE_EN to add the peak-count register behind peak_out/peak_clr.
module pix_goe_counter #(
    parameter int N_PIX  = 256,
    parameter int FAN_IN = 4,
    parameter int CNT_W  = $clog2(N_PIX + 1),
    parameter int HOLD_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_PIX-1:0]  hit_in,
    input  logic              hit_valid,
    input  logic [N_PIX-1:0]  pix_mask,
    input  logic [CNT_W-1:0]  thr_lo,
    input  logic [CNT_W-1:0]  thr_hi,
    input  logic [HOLD_W-1:0] hold_len,
    input  logic              cfg_load,
    output logic [CNT_W-1:0]  count_out,
    output logic              count_valid,
    output logic              goe_lo,
    output logic              goe_hi,
    output logic [CNT_W-1:0]  peak_out,
    input  logic              peak_clr
);

    function automatic int ipow(int b, int e);
        int r = 1;
        for (int i = 0; i < e; i++) r = r * b;
        return r;
    endfunction

    function automatic int num_levels(int n, int f);
        int l = 0;
        int span = 1;
        while (span < n) begin
            span = span * f;
            l++;
        end
        return l;
    endfunction

    function automatic int lvl_nodes(int n, int f, int l);
        return (n + ipow(f, l) - 1) / ipow(f, l);
    endfunction

    // Widest possible sum at level l is the number of leaves below one node, capped at N_PIX.
    function automatic int lvl_width(int n, int f, int l);
        int span = ipow(f, l);
        if (span > n) span = n;
        return $clog2(span + 1);
    endfunction

    localparam int LEV = num_levels(N_PIX, FAN_IN);

    genvar gi, gj;

    // Stage 0: masked hits; invalid samples enter the tree as all-zero so they count 0.
    logic [N_PIX-1:0] hit_reg;
    logic [LEV:0]     vld_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_reg <= '0;
            vld_reg <= '0;
        end else begin
            hit_reg <= hit_valid ? (hit_in & ~pix_mask) : '0;
            vld_reg <= {vld_reg[LEV-1:0], hit_valid};
        end
    end

    for (gi = 1; gi <= LEV; gi++) begin : lvl
        localparam int NODES      = lvl_nodes(N_PIX, FAN_IN, gi);
        localparam int PREV_NODES = lvl_nodes(N_PIX, FAN_IN, gi - 1);
        localparam int W          = lvl_width(N_PIX, FAN_IN, gi);

        logic [W-1:0] child    [NODES*FAN_IN];
        logic [W-1:0] sum_next [NODES];
        logic [W-1:0] sum_reg  [NODES];

        for (gj = 0; gj < NODES * FAN_IN; gj++) begin : leaf
            if (gj >= PREV_NODES) begin : g_pad
                assign child[gj] = '0;
            end else if (gi == 1) begin : g_hit
                assign child[gj] = W'(hit_reg[gj]);
            end else begin : g_sum
                assign child[gj] = W'(lvl[gi-1].sum_reg[gj]);
            end
        end

        always_comb begin
            for (int n = 0; n < NODES; n++) begin
                sum_next[n] = '0;
                for (int k = 0; k < FAN_IN; k++) begin
                    sum_next[n] = sum_next[n] + child[n*FAN_IN + k];
                end
            end
        end

        always_ff @(posedge clk) begin
            for (int n = 0; n < NODES; n++) begin
                sum_reg[n] <= rst ? '0 : sum_next[n];
            end
        end
    end

    logic [CNT_W-1:0] tree_sum;
    logic             tree_vld;

    assign tree_sum = CNT_W'(lvl[LEV].sum_reg[0]);
    assign tree_vld = vld_reg[LEV];

    logic [CNT_W-1:0]  count_out_reg;
    logic              count_valid_reg;
    logic [HOLD_W-1:0] hold_act_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_out_reg   <= '0;
            count_valid_reg <= 1'b0;
            hold_act_reg    <= '0;
        end else begin
            count_valid_reg <= tree_vld;
            if (tree_vld) count_out_reg <= tree_sum;
            if (cfg_load) hold_act_reg <= hold_len;
        end
    end

    logic [CNT_W-1:0] thr_shadow [2];
    logic [1:0]       goe_bits;

    assign thr_shadow[0] = thr_lo;
    assign thr_shadow[1] = thr_hi;

    // Channel 0 is goe_lo, channel 1 is goe_hi; a zero threshold disables its channel.
    for (gi = 0; gi < 2; gi++) begin : ch
        logic [CNT_W-1:0]  thr_act_reg;
        logic [HOLD_W-1:0] hold_cnt_reg;
        logic              goe_reg;
        logic              cmp;

        assign cmp = tree_vld && (thr_act_reg != '0) && (tree_sum >= thr_act_reg);

        always_ff @(posedge clk) begin
            if (rst) begin
                thr_act_reg  <= '1;
                hold_cnt_reg <= '0;
                goe_reg      <= 1'b0;
            end else begin
                if (cfg_load) thr_act_reg <= thr_shadow[gi];
                if (cmp) begin
                    hold_cnt_reg <= hold_act_reg;
                    goe_reg      <= 1'b1;
                end else if (hold_cnt_reg != '0) begin
                    hold_cnt_reg <= hold_cnt_reg - HOLD_W'(1);
                    goe_reg      <= 1'b1;
                end else begin
                    goe_reg      <= 1'b0;
                end
            end
        end

        assign goe_bits[gi] = goe_reg;
    end

    assign count_out   = count_out_reg;
    assign count_valid = count_valid_reg;
    assign goe_lo      = goe_bits[0];
    assign goe_hi      = goe_bits[1];

`ifdef PIX_GOE_PEAK_CAPTURE_EN
    logic [CNT_W-1:0] peak_reg;

    // Clear wins over a same-cycle update, so that cycle's count is dropped.
    always_ff @(posedge clk) begin
        if (rst || peak_clr) begin
            peak_reg <= '0;
        end else if (count_valid_reg && (count_out_reg > peak_reg)) begin
            peak_reg <= count_out_reg;
        end
    end

    assign peak_out = peak_reg;
`else
    logic unused_peak_clr;

    assign unused_peak_clr = peak_clr;
    assign peak_out        = '0;
`endif

endmodule
